// File: rtl/spi_pkg.sv
// Shared SPI link definitions used by the transmit controller and the receiver.
package spi_pkg;

   localparam int unsigned SPI_BITS       = 8;
   localparam int unsigned SPI_CNT_W      = $clog2(SPI_BITS);
   localparam logic        SPI_IDLE_LEVEL = 1'b1;

   typedef enum logic {
      SPI_RX_IDLE,
      SPI_RX_SHIFT
   } spi_rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for spi_clock/spi_data plus a third clock flop
// so the receiver sees a single-cycle rising-edge strobe.
module spi_sync_edge
   import spi_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic spi_clock_i,
   input  logic spi_data_i,
   output logic rise_o,
   output logic data_o
);

   logic [2:0] sclk_q;
   logic [1:0] sdat_q;

   // Idle-level reset keeps reset release from looking like a rise.
   always_ff @(posedge clock) begin
      if (reset) begin
         sclk_q <= {3{SPI_IDLE_LEVEL}};
         sdat_q <= {2{SPI_IDLE_LEVEL}};
      end else begin
         sclk_q <= {sclk_q[1:0], spi_clock_i};
         sdat_q <= {sdat_q[0], spi_data_i};
      end
   end

   assign rise_o = sclk_q[1] & ~sclk_q[2];
   assign data_o = sdat_q[1];

endmodule

// File: rtl/spi_receiver.sv
// SPI byte receiver with single-entry valid/ready holding register.
// Optional partial-byte timeout enabled by defining SPI_RX_TIMEOUT_EN.
module spi_receiver
   import spi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                spi_clock,
   input  logic                spi_data,
   output logic [SPI_BITS-1:0] data_out,
   output logic                data_valid,
   input  logic                data_ready,
   output logic                overrun,
   output logic                frame_error,
   output logic                busy
);

   localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_BITS - 1);

   logic                 rise;
   logic                 sbit;
   logic                 load;
   logic                 timeout;
   logic [SPI_BITS-1:0]  byte_nxt;

   spi_rx_state_e        state_q, state_d;
   logic [SPI_CNT_W-1:0] cnt_q, cnt_d;
   logic [SPI_BITS-1:0]  shift_q, shift_d;
   logic [SPI_BITS-1:0]  hold_q, hold_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;

   spi_sync_edge u_sync (
      .clock       (clock),
      .reset       (reset),
      .spi_clock_i (spi_clock),
      .spi_data_i  (spi_data),
      .rise_o      (rise),
      .data_o      (sbit)
   );

   assign byte_nxt = {shift_q[SPI_BITS-2:0], sbit};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      load    = 1'b0;
      if (timeout) begin
         state_d = SPI_RX_IDLE;
         cnt_d   = '0;
      end else if (rise) begin
         shift_d = byte_nxt;
         unique case (state_q)
            SPI_RX_IDLE: begin
               cnt_d   = SPI_CNT_W'(1);
               state_d = SPI_RX_SHIFT;
            end
            SPI_RX_SHIFT: begin
               if (cnt_q == LAST_BIT) begin
                  load    = 1'b1;
                  cnt_d   = '0;
                  state_d = SPI_RX_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = SPI_RX_IDLE;
         endcase
      end
   end

   // A load always wins over a handshake so data_valid stays set.
   always_comb begin
      hold_d  = hold_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (load) begin
         hold_d  = byte_nxt;
         valid_d = 1'b1;
         ovr_d   = valid_q & ~data_ready;
      end else if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= SPI_RX_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         hold_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef SPI_RX_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

   logic [IDLE_W-1:0] idle_q, idle_d;

   always_comb begin
      idle_d = idle_q;
      if (state_q == SPI_RX_IDLE || rise) begin
         idle_d = '0;
      end else if (idle_q != IDLE_MAX) begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

   assign timeout = (state_q == SPI_RX_SHIFT) && (idle_q == IDLE_MAX);
`else
   logic cfg_unused;
   assign cfg_unused = ^TIMEOUT_CYCLES;
   assign timeout    = 1'b0;
`endif

   assign data_out    = hold_q;
   assign data_valid  = valid_q;
   assign overrun     = ovr_q;
   assign frame_error = timeout;
   assign busy        = (state_q == SPI_RX_SHIFT);

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: latency, back-to-back, overrun,
// coincident handshake, timeout/stall and mid-byte reset.
module tb_spi_receiver;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       spi_clock = 1'b1;
   logic       spi_data = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready = 1'b1;
   logic       overrun;
   logic       frame_error;
   logic       busy;

   int total = 0;
   int bad = 0;
   int ovr_cnt = 0;
   int fe_cnt = 0;
   logic [7:0] rxq[$];

   spi_receiver #(.TIMEOUT_CYCLES(64)) dut (
      .clock       (clock),
      .reset       (reset),
      .spi_clock   (spi_clock),
      .spi_data    (spi_data),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .overrun     (overrun),
      .frame_error (frame_error),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   // Inputs change 1 time unit after posedge, so the negedge view
   // is what the next posedge will act on.
   always @(negedge clock) begin
      if (!reset) begin
         if (data_valid && data_ready) rxq.push_back(data_out);
         if (overrun) ovr_cnt++;
         if (frame_error) fe_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bit_low(input logic b);
      tick();
      spi_clock = 1'b0;
      spi_data  = b;
      repeat (4) tick();
   endtask

   task automatic bit_high();
      tick();
      spi_clock = 1'b1;
      repeat (4) tick();
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         bit_low(b[i]);
         bit_high();
      end
   endtask

   initial begin
      logic [7:0] v;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_valid", data_valid, 0);
      check("rst_data", data_out, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_ovr", overrun, 0);
      check("rst_fe", frame_error, 0);

      // 0xA5 with the last rise timed cycle by cycle
      v = 8'hA5;
      send_bits(v, 7);
      bit_low(v[0]);
      tick();
      spi_clock = 1'b1;
      tick();
      tick();
      check("a5_early", data_valid, 0);
      tick();
      check("a5_valid", data_valid, 1);
      check("a5_data", data_out, 8'hA5);
      tick();
      check("a5_drop", data_valid, 0);
      repeat (3) tick();
      check("a5_cnt", rxq.size(), 1);
      if (rxq.size() > 0) check("a5_q", rxq[0], 8'hA5);
      rxq.delete();

      // back-to-back bytes, no gap
      send_bits(8'h3C, 8);
      send_bits(8'hC3, 8);
      repeat (4) tick();
      check("b2b_cnt", rxq.size(), 2);
      if (rxq.size() == 2) begin
         check("b2b_0", rxq[0], 8'h3C);
         check("b2b_1", rxq[1], 8'hC3);
      end
      check("b2b_ovr", ovr_cnt, 0);
      rxq.delete();

      // overrun with consumer stalled
      data_ready = 1'b0;
      send_bits(8'h11, 8);
      send_bits(8'h22, 8);
      repeat (4) tick();
      check("ovr_cnt", ovr_cnt, 1);
      check("ovr_data", data_out, 8'h22);
      check("ovr_valid", data_valid, 1);
      check("ovr_q0", rxq.size(), 0);
      data_ready = 1'b1;
      tick();
      check("ovr_drop", data_valid, 0);
      check("ovr_q1", rxq.size(), 1);
      if (rxq.size() > 0) check("ovr_qd", rxq[0], 8'h22);
      rxq.delete();

      // handshake in the same cycle as the 8th-bit load
      data_ready = 1'b0;
      send_bits(8'h55, 8);
      v = 8'h77;
      send_bits(v, 7);
      bit_low(v[0]);
      tick();
      spi_clock = 1'b1;
      tick();
      tick();
      data_ready = 1'b1;
      tick();
      check("co_valid", data_valid, 1);
      check("co_data", data_out, 8'h77);
      check("co_ovr", overrun, 0);
      tick();
      check("co_drop", data_valid, 0);
      check("co_ovrcnt", ovr_cnt, 1);
      check("co_cnt", rxq.size(), 2);
      if (rxq.size() == 2) begin
         check("co_q0", rxq[0], 8'h55);
         check("co_q1", rxq[1], 8'h77);
      end
      rxq.delete();

      // stall after 3 bits
      send_bits(8'hB4, 3);
      check("st_busy0", busy, 1);
`ifdef SPI_RX_TIMEOUT_EN
      for (int i = 0; i < 200 && fe_cnt == 0; i++) tick();
      check("to_fe", fe_cnt, 1);
      tick();
      check("to_busy", busy, 0);
      send_bits(8'h5A, 8);
      repeat (4) tick();
      check("to_fe1", fe_cnt, 1);
      check("to_cnt", rxq.size(), 1);
      if (rxq.size() > 0) check("to_q", rxq[0], 8'h5A);
`else
      repeat (150) tick();
      check("st_fe", fe_cnt, 0);
      check("st_busy", busy, 1);
      v = 8'hB4;
      v = v << 3;
      send_bits(v, 5);
      repeat (4) tick();
      check("st_cnt", rxq.size(), 1);
      if (rxq.size() > 0) check("st_q", rxq[0], 8'hB4);
`endif
      rxq.delete();

      // reset in the middle of 0xF0
      send_bits(8'hF0, 4);
      check("mr_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_valid", data_valid, 0);
      check("mr_data", data_out, 8'h00);
      check("mr_busy0", busy, 0);
      check("mr_ovr", overrun, 0);
      check("mr_fe", frame_error, 0);
      send_bits(8'h0F, 8);
      repeat (4) tick();
      check("mr_cnt", rxq.size(), 1);
      if (rxq.size() > 0) check("mr_q", rxq[0], 8'h0F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
